// File: rtl/vcve2_vlsu_sequencer_if.sv
// LSU bus bundle between the vector sequencer (master) and the core LSU (slave).
// Signal names mirror the lsu_* ports of the sequencer without direction suffixes.
interface vcve2_vlsu_sequencer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  err,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output err,
    output rdata
  );
endinterface

// File: rtl/vcve2_vlsu_sequencer.sv
// Splits one vector load/store into single-element LSU transactions,
// one outstanding at a time; passes scalar LSU traffic through when idle.
module vcve2_vlsu_sequencer #(
  parameter int unsigned VL_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [31:0]           base_addr_i,
  input  logic [31:0]           stride_i,
  input  logic [VL_W-1:0]       vl_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,

  input  logic                  scalar_req_i,
  input  logic [31:0]           scalar_addr_i,
  input  logic                  scalar_we_i,
  input  logic [31:0]           scalar_wdata_i,
  output logic                  scalar_gnt_o,

  vcve2_vlsu_sequencer_if.master lsu,

  output logic [VL_W-1:0]       vrf_idx_o,
  input  logic [31:0]           vrf_rdata_i,
  output logic                  vrf_we_o,
  output logic [31:0]           vrf_wdata_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [VL_W-1:0] idx_q, idx_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     stride_q, stride_d;
  logic            store_q, store_d;
  logic            err_q, err_d;

  logic            idle;
  logic            in_req;
  logic            in_wait;
  logic            last_elem;
  logic            resp_ok;

  assign idle      = (state_q == S_IDLE);
  assign in_req    = (state_q == S_REQ);
  assign in_wait   = (state_q == S_WAIT);
  assign last_elem = (idx_q == vl_q - 1'b1);
  assign resp_ok   = in_wait & lsu.rvalid & ~lsu.err;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vl_d     = vl_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    store_d  = store_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          store_d  = is_store_i;
          addr_d   = base_addr_i;
          stride_d = stride_i;
          vl_d     = vl_i;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = (vl_i == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (lsu.gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lsu.rvalid) begin
          if (lsu.err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (last_elem) begin
            state_d = S_DONE;
          end else begin
            // Address wraps modulo 2**32; negative strides walk down.
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + stride_q;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      vl_q     <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      store_q  <= store_d;
      err_q    <= err_d;
    end
  end

  // The LSU port belongs to the scalar pipe only while idle.
  always_comb begin
    if (idle) begin
      lsu.req   = scalar_req_i;
      lsu.we    = scalar_we_i;
      lsu.addr  = scalar_addr_i;
      lsu.wdata = scalar_wdata_i;
    end else begin
      lsu.req   = in_req;
      lsu.we    = in_req & store_q;
      lsu.addr  = addr_q;
      lsu.wdata = vrf_rdata_i;
    end
  end

  assign scalar_gnt_o = idle & lsu.gnt;
  assign busy_o       = ~idle;
  assign done_o       = (state_q == S_DONE);
  assign err_o        = done_o & err_q;

  assign vrf_idx_o    = idx_q;
  assign vrf_we_o     = resp_ok & ~store_q;
  assign vrf_wdata_o  = lsu.rdata;

endmodule

// File: tb/tb_vcve2_vlsu_sequencer.sv
// Scoreboard bench: directed vector ops push expected LSU requests,
// VRF writes and completions; a negedge monitor pops and compares.
module tb_vcve2_vlsu_sequencer;
  localparam int VL_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, is_store;
  logic [31:0]     base, stride;
  logic [VL_W-1:0] vl;
  logic            busy, done, err;
  logic            s_req, s_we, s_gnt;
  logic [31:0]     s_addr, s_wdata;
  logic [VL_W-1:0] vrf_idx;
  logic [31:0]     vrf_rdata, vrf_wdata;
  logic            vrf_we;

  vcve2_vlsu_sequencer_if lsu ();

  vcve2_vlsu_sequencer #(.VL_W(VL_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .is_store_i     (is_store),
    .base_addr_i    (base),
    .stride_i       (stride),
    .vl_i           (vl),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .scalar_req_i   (s_req),
    .scalar_addr_i  (s_addr),
    .scalar_we_i    (s_we),
    .scalar_wdata_i (s_wdata),
    .scalar_gnt_o   (s_gnt),
    .lsu            (lsu),
    .vrf_idx_o      (vrf_idx),
    .vrf_rdata_i    (vrf_rdata),
    .vrf_we_o       (vrf_we),
    .vrf_wdata_o    (vrf_wdata)
  );

  assign vrf_rdata = 32'hA5A5_0000 | {27'd0, vrf_idx};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    logic [VL_W-1:0] idx;
    logic [31:0]     data;
  } vw_t;
  typedef struct {
    logic err;
    int   dly;
  } dn_t;

  req_t exp_req[$];
  vw_t  exp_vw[$];
  dn_t  exp_dn[$];

  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc++;

  // LSU model: grant after gnt_delay cycles, respond one cycle later.
  int   gnt_delay = 0;
  int   err_at = -1;
  int   wait_cnt = 0;
  int   resp_cnt = 0;
  logic pend = 1'b0;
  logic [31:0] pend_addr = '0;
  always @(posedge clk) begin
    #1;
    if (!busy) resp_cnt = 0;
    lsu.rvalid = 1'b0;
    lsu.err    = 1'b0;
    lsu.rdata  = 32'h0;
    if (pend) begin
      lsu.rvalid = 1'b1;
      lsu.err    = (resp_cnt == err_at);
      lsu.rdata  = 32'hD000_0000 + pend_addr;
      resp_cnt++;
      pend = 1'b0;
    end
    lsu.gnt = 1'b0;
    if (!lsu.req) begin
      wait_cnt = 0;
    end else if (wait_cnt < gnt_delay) begin
      wait_cnt++;
    end else begin
      lsu.gnt  = 1'b1;
      wait_cnt = 0;
      if (busy) begin
        pend      = 1'b1;
        pend_addr = lsu.addr;
      end
    end
  end

  logic        stall_v = 1'b0;
  logic [31:0] stall_addr = '0, stall_wdata = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_v && lsu.req) begin
        chk("stall_addr", lsu.addr, stall_addr);
        chk("stall_wdata", lsu.wdata, stall_wdata);
      end
      stall_v     = busy && lsu.req && !lsu.gnt;
      stall_addr  = lsu.addr;
      stall_wdata = lsu.wdata;
      if (busy && s_req) chk("scalar_gnt_busy", {31'd0, s_gnt}, 32'd0);
      if (lsu.req && lsu.gnt) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req", lsu.addr, ~lsu.addr);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          chk("req_addr", lsu.addr, r.addr);
          chk("req_we", {31'd0, lsu.we}, {31'd0, r.we});
          if (r.we) chk("req_wdata", lsu.wdata, r.wdata);
        end
      end
      if (vrf_we) begin
        if (exp_vw.size() == 0) begin
          chk("unexpected_vrf_we", {27'd0, vrf_idx}, 32'hFFFF_FFFF);
        end else begin
          vw_t v;
          v = exp_vw.pop_front();
          chk("vrf_idx", {27'd0, vrf_idx}, {27'd0, v.idx});
          chk("vrf_wdata", vrf_wdata, v.data);
        end
      end
      if (err && !done) chk("err_without_done", 32'd1, 32'd0);
      if (done) begin
        done_cnt++;
        if (exp_dn.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          dn_t d;
          d = exp_dn.pop_front();
          chk("done_err", {31'd0, err}, {31'd0, d.err});
          if (d.dly >= 0) chk("done_latency", cyc - start_cyc, d.dly);
        end
      end
    end
  end

  task automatic push_req(input logic [31:0] a, input logic w,
                          input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = w; r.wdata = wd;
    exp_req.push_back(r);
  endtask

  task automatic push_vw(input int i, input logic [31:0] d);
    vw_t v;
    v.idx = VL_W'(i); v.data = d;
    exp_vw.push_back(v);
  endtask

  task automatic push_dn(input logic e, input int dly);
    dn_t d;
    d.err = e; d.dly = dly;
    exp_dn.push_back(d);
  endtask

  task automatic run_op(input logic st, input logic [31:0] b,
                        input logic [31:0] s, input int n);
    @(posedge clk); #1;
    start = 1'b1; is_store = st; base = b; stride = s; vl = VL_W'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; is_store = ~st; base = 32'hDEAD_BEEF;
    stride = 32'h0; vl = VL_W'(7);
  endtask

  task automatic wait_done(input string nm);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == d0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_req_left"}, exp_req.size(), 32'd0);
    chk({nm, "_vrf_left"}, exp_vw.size(), 32'd0);
  endtask

  initial begin
    start = 0; is_store = 0; base = 0; stride = 0; vl = 0;
    s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_lsu_req", {31'd0, lsu.req}, 32'd0);
    chk("rst_vrf_we", {31'd0, vrf_we}, 32'd0);
    chk("rst_vrf_idx", {27'd0, vrf_idx}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Unit-stride load; a stray start mid-op must be ignored.
    push_req(32'h1000, 0, 0); push_req(32'h1004, 0, 0);
    push_req(32'h1008, 0, 0); push_req(32'h100C, 0, 0);
    push_vw(0, 32'hD000_1000); push_vw(1, 32'hD000_1004);
    push_vw(2, 32'hD000_1008); push_vw(3, 32'hD000_100C);
    push_dn(0, 9);
    run_op(0, 32'h1000, 32'd4, 4);
    @(posedge clk); #1 start = 1'b1; base = 32'h9999;
    @(posedge clk); #1 start = 1'b0;
    wait_done("load4");

    // Negative-stride store.
    push_req(32'h20, 1, 32'hA5A5_0000);
    push_req(32'h18, 1, 32'hA5A5_0001);
    push_req(32'h10, 1, 32'hA5A5_0002);
    push_dn(0, 7);
    run_op(1, 32'h20, 32'hFFFF_FFF8, 3);
    wait_done("store3");

    push_dn(0, 1);
    run_op(0, 32'h40, 32'd4, 0);
    wait_done("vl0");

    // Bus error on element 2 aborts the op.
    err_at = 2;
    push_req(32'h200, 0, 0); push_req(32'h204, 0, 0);
    push_req(32'h208, 0, 0);
    push_vw(0, 32'hD000_0200); push_vw(1, 32'hD000_0204);
    push_dn(1, 7);
    run_op(0, 32'h200, 32'd4, 4);
    wait_done("err2");
    err_at = -1;

    // Scalar request stalls behind the vector op, then is granted.
    push_req(32'h300, 0, 0);
    push_vw(0, 32'hD000_0300);
    push_dn(0, 3);
    push_req(32'h4000, 1, 32'h1234);
    run_op(0, 32'h300, 32'd4, 1);
    s_req = 1; s_we = 1; s_addr = 32'h4000; s_wdata = 32'h1234;
    begin
      int k;
      k = 0;
      while (!s_gnt && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("scalar_gnt_idle", {31'd0, s_gnt}, 32'd1);
    end
    @(posedge clk); #1 s_req = 0; s_we = 0;
    chk("scalar_req_left", exp_req.size(), 32'd0);
    chk("scalar_done_left", exp_dn.size(), 32'd0);

    // Delayed grant plus address wrap past 2**32.
    gnt_delay = 3;
    push_req(32'hFFFF_FFFC, 0, 0); push_req(32'h0, 0, 0);
    push_vw(0, 32'hCFFF_FFFC); push_vw(1, 32'hD000_0000);
    push_dn(0, -1);
    run_op(0, 32'hFFFF_FFFC, 32'd4, 2);
    wait_done("wrap");
    gnt_delay = 0;

    // Reset mid-op: back to idle, no done, late response ignored.
    push_req(32'h500, 0, 0); push_req(32'h504, 0, 0);
    push_vw(0, 32'hD000_0500);
    run_op(0, 32'h500, 32'd4, 4);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_lsu_req", {31'd0, lsu.req}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    chk("postrst_req_left", exp_req.size(), 32'd0);
    chk("postrst_vrf_left", exp_vw.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
